cp0_exc_ctrl: RTL

Coprocessor-0 exception controller. It sits beside the M stage and consumes the exception code, branch-delay flag and victim PC that the pipeline registers carry down from F/D/E. It raises `req`, which flushes every pipeline register and redirects fetch to the handler at 0x0000_4180. It also holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and returns EPC for eret.

---
 rtl/cp0_exc_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: holds SR/Cause/EPC/PRId, raises the
// pipeline-flush request for interrupts and exceptions seen at the M stage,
// serves mfc0/mtc0 and supplies the eret return address.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID     = 32'h0000_2021,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  ex_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC
  logic [31:0] epc;

  logic int_req, exc_req;
  logic [31:0] sr_val, cause_val;

  // Interrupts need IE and an unmasked line; EXL blocks everything so a
  // handler is never re-entered by a second event.
  always_comb begin
    int_req = (|(hw_int & im)) & ie & ~exl;
    exc_req = (ex_code_in != 5'd0) & ~exl;
    req     = int_req | exc_req;
  end

  // Architectural register images with unimplemented bits tied to zero.
  always_comb begin
    sr_val    = {16'd0, im, 8'd0, exl, ie};
    cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  end

  // Register updates: a taken request overrides mtc0/eret; otherwise the
  // SR write lands first and a same-cycle eret then clears EXL.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= SR_RESET[15:10];
      exl      <= SR_RESET[1];
      ie       <= SR_RESET[0];
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bd_in;
        exc_code <= int_req ? 5'd0 : ex_code_in;
        epc      <= bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (we && cp0_addr == A_SR) begin
          im  <= cp0_wdata[15:10];
          exl <= cp0_wdata[1];
          ie  <= cp0_wdata[0];
        end
        if (we && cp0_addr == A_EPC)
          epc <= cp0_wdata;
        if (eret)
          exl <= 1'b0;
      end
    end
  end

  // mfc0 read mux; shows pre-edge state, no write bypass.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      A_SR:    cp0_rdata = sr_val;
      A_CAUSE: cp0_rdata = cause_val;
      A_EPC:   cp0_rdata = epc;
      A_PRID:  cp0_rdata = PRID;
      default: cp0_rdata = 32'd0;
    endcase
  end

  // eret target, forwarding an in-flight mtc0 EPC so mtc0+eret back-to-back works.
  always_comb begin
    epc_out = (we && cp0_addr == A_EPC) ? cp0_wdata : epc;
  end

endmodule
